branch_resolve_unit: RTL and testbench

Parametrised branch resolution stage for the MIPS32 pipeline, the successor to the single-mode BEQ comparator. Evaluates six MIPS branch conditions plus unconditional jump. Registers the decision behind a valid/ready handshake and detects mispredicts against the predicted direction carried with each request. Owns a 2-bit saturating branch history table (BHT) that the fetch stage reads and this block trains on every accepted branch.

---
 rtl/branch_pkg.sv | 40 ++++
 rtl/branch_history_table.sv | 36 +++
 rtl/branch_resolve_unit.sv | 147 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution stage.
//   br_op_e      : branch condition encodings carried on br_op
//   bht_state_e  : 2-bit saturating predictor counter states
//   BHT_RESET    : state every history entry takes on reset
//   sat_update() : saturating increment/decrement of a predictor counter
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5,
    BR_JUMP = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  localparam bht_state_e BHT_RESET = WNT;

  // Move a counter one step toward taken or not-taken, holding at the ends.
  function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic inc);
    logic [1:0] nxt;
    nxt = cur;
    if (inc) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Branch history table of 2-bit saturating counters.
//   clk, rst       : clock and asynchronous active-high reset (entries -> WNT)
//   rd_idx_i       : combinational read index
//   rd_state_o     : counter at rd_idx_i, pre-update value within the cycle
//   upd_en_i       : train the entry at upd_idx_i on this rising edge
//   upd_idx_i      : entry to train
//   upd_taken_i    : 1 = step toward taken, 0 = step toward not-taken
module branch_history_table
  import branch_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_state_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] tbl_q [BHT_DEPTH];

  // Read straight from the registers so a same-cycle update is not forwarded.
  assign rd_state_o = tbl_q[rd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) tbl_q[i] <= BHT_RESET;
    end else if (upd_en_i) begin
      tbl_q[upd_idx_i] <= sat_update(tbl_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates the MIPS branch conditions, registers
// the decision in a one-entry output stage, flags mispredicts, trains the
// branch history table and keeps a saturating mispredict counter.
//   clk, reset             : clock, asynchronous active-high reset
//   in_valid / in_ready    : request handshake
//   br_op, rs_val, rt_val  : condition code and operands
//   br_pc, br_target       : branch PC and taken target
//   pred_taken             : fetch-stage predicted direction
//   out_valid / out_ready  : result handshake
//   taken, mispredict, redirect_pc, illegal_op : registered result
//   lookup_pc / lookup_taken : fetch-stage prediction read port
//   mispredict_count       : saturating count of delivered mispredicts
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload until it transfers;
// ready may depend combinationally on the other side's state. The result
// register frees up when it is empty or being drained in the same cycle,
// so in_ready = !out_valid || out_ready gives one result per cycle.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int BHT_DEPTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            br_op,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  input  logic [PC_WIDTH-1:0]   br_pc,
  input  logic [PC_WIDTH-1:0]   br_target,
  input  logic                  pred_taken,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  taken,
  output logic                  mispredict,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  illegal_op,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  lookup_taken,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic                 out_valid_q, out_valid_d;
  logic                 taken_q, taken_d;
  logic                 mispredict_q, mispredict_d;
  logic                 illegal_q, illegal_d;
  logic [PC_WIDTH-1:0]  redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic       accept;
  logic       rs_neg, rs_zero;
  logic       trains;
  logic [1:0] lookup_state;

  // Only the index field of the lookup PC selects an entry.
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[PC_WIDTH-1:2+IDX_W], lookup_pc[1:0]};

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign rs_neg  = rs_val[DATA_WIDTH-1];
  assign rs_zero = (rs_val == '0);

  // Decision is fully assigned for every op, reserved included.
  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (br_op)
      BR_BEQ:  taken_d = (rs_val == rt_val);
      BR_BNE:  taken_d = (rs_val != rt_val);
      BR_BLEZ: taken_d = rs_neg || rs_zero;
      BR_BGTZ: taken_d = !rs_neg && !rs_zero;
      BR_BLTZ: taken_d = rs_neg;
      BR_BGEZ: taken_d = !rs_neg;
      BR_JUMP: taken_d = 1'b1;
      default: illegal_d = 1'b1;
    endcase
  end

  assign mispredict_d = taken_d != pred_taken;
  assign redirect_d   = taken_d ? br_target : br_pc + PC_WIDTH'(4);

  // Only conditional branches train the predictor.
  assign trains = accept && (br_op != BR_JUMP) && (br_op != BR_RSVD);

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // Count mispredicts as they leave, holding at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready && mispredict_q && (cnt_q != '1))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= '0;
      cnt_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        taken_q      <= taken_d;
        mispredict_q <= mispredict_d;
        illegal_q    <= illegal_d;
        redirect_q   <= redirect_d;
      end
    end
  end

  branch_history_table #(
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk         (clk),
    .rst         (reset),
    .rd_idx_i    (lookup_pc[2 +: IDX_W]),
    .rd_state_o  (lookup_state),
    .upd_en_i    (trains),
    .upd_idx_i   (br_pc[2 +: IDX_W]),
    .upd_taken_i (taken_d)
  );

  assign lookup_taken     = lookup_state[1];
  assign out_valid        = out_valid_q;
  assign taken            = taken_q;
  assign mispredict       = mispredict_q;
  assign illegal_op       = illegal_q;
  assign redirect_pc      = redirect_q;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int BD = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    br_op = '0;
  logic [DW-1:0] rs_val = '0;
  logic [DW-1:0] rt_val = '0;
  logic [PW-1:0] br_pc = '0;
  logic [PW-1:0] br_target = '0;
  logic          pred_taken = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          taken;
  logic          mispredict;
  logic [PW-1:0] redirect_pc;
  logic          illegal_op;
  logic [PW-1:0] lookup_pc = '0;
  logic          lookup_taken;
  logic [CW-1:0] mispredict_count;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  branch_resolve_unit #(
    .DATA_WIDTH (DW),
    .PC_WIDTH   (PW),
    .BHT_DEPTH  (BD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .br_op            (br_op),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .br_pc            (br_pc),
    .br_target        (br_target),
    .pred_taken       (pred_taken),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .taken            (taken),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .illegal_op       (illegal_op),
    .lookup_pc        (lookup_pc),
    .lookup_taken     (lookup_taken),
    .mispredict_count (mispredict_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = '0;
  endtask

  // ---------------- driver tasks ----------------
  // Presents one request for one edge; returns 1 time unit after that edge.
  task automatic send(input logic [2:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                      input logic [PW-1:0] pc, input logic [PW-1:0] tgt, input logic pred);
    in_valid   = 1'b1;
    br_op      = op;
    rs_val     = rs;
    rt_val     = rt;
    br_pc      = pc;
    br_target  = tgt;
    pred_taken = pred;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Expected counter: one step per delivered mispredict, holding at all-ones.
  task automatic note_delivery(input logic mis);
    if (mis && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (mispredict_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", mispredict_count); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL rst_taken: got %b expected 0", taken); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rst_mispredict: got %b expected 0", mispredict); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b expected 0", illegal_op); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect: got %h expected 00000000", redirect_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < BD; i++) begin
      lookup_pc = 32'(i) << 2;
      #0.1;
      checks++; if (lookup_taken !== 1'b0) begin errors++; $display("FAIL rst_lookup[%0d]: got %b expected 0", i, lookup_taken); end
    end
    lookup_pc = 32'h0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    send(BR_BEQ, 32'h5, 32'h5, 32'h100, 32'h200, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL beq_valid: got %b expected 1", out_valid); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b expected 1", taken); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL beq_redirect: got %h expected 00000200", redirect_pc); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL beq_illegal: got %b expected 0", illegal_op); end
    note_delivery(1'b1);
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL beq_drained: got %b expected 0", out_valid); end
    checks++; if (mispredict_count !== 3'd1) begin errors++; $display("FAIL beq_count: got %0d expected 1", mispredict_count); end
  endtask

  task automatic test_conditions();
    logic [2:0]    vop   [15];
    logic [DW-1:0] vrs   [15];
    logic [DW-1:0] vrt   [15];
    logic          vpred [15];
    logic          vtk   [15];
    logic [PW-1:0] exp_redir;
    vop   = '{BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ,
              BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ,
              BR_BLEZ, BR_BGTZ, BR_BLEZ, BR_BGTZ,
              BR_BNE,  BR_BNE,  BR_JUMP};
    vrs   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h0, 32'h0, 32'h0, 32'h0,
              32'h5, 32'h5, 32'h80000000, 32'h7FFFFFFF,
              32'h3, 32'h3, 32'h0};
    vrt   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h4, 32'h9};
    vpred = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vtk   = '{1'b1, 1'b0, 1'b1, 1'b0,
              1'b1, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(vop[i], vrs[i], vrt[i], 32'h300, 32'h400, vpred[i]);
      exp_redir = vtk[i] ? 32'h400 : 32'h304;
      checks++; if (taken !== vtk[i]) begin errors++; $display("FAIL cond_taken[%0d]: got %b expected %b", i, taken, vtk[i]); end
      checks++; if (mispredict !== (vtk[i] ^ vpred[i])) begin errors++; $display("FAIL cond_mispredict[%0d]: got %b expected %b", i, mispredict, vtk[i] ^ vpred[i]); end
      checks++; if (redirect_pc !== exp_redir) begin errors++; $display("FAIL cond_redirect[%0d]: got %h expected %h", i, redirect_pc, exp_redir); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cond_valid[%0d]: got %b expected 1", i, out_valid); end
      note_delivery(vtk[i] ^ vpred[i]);
    end
    idle();
    checks++; if (mispredict_count !== exp_cnt) begin errors++; $display("FAIL cond_count: got %0d expected %0d", mispredict_count, exp_cnt); end
  endtask

  task automatic test_bht_training();
    // Sequence on the entry for pc 0x40, starting from reset (01).
    logic [2:0]    sop [10];
    logic [DW-1:0] srt [10];
    logic          slk [10];
    logic          stk [10];
    sop = '{BR_BEQ, BR_BEQ, BR_BEQ, BR_BEQ, BR_BEQ, BR_BEQ, BR_BEQ, BR_BEQ, BR_BEQ, BR_JUMP};
    srt = '{32'h7, 32'h7, 32'h7, 32'h8, 32'h8, 32'h8, 32'h8, 32'h7, 32'h8, 32'h7};
    stk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    // 10,11,11 | 10,01,00,00 | 01,00 | JUMP leaves 00
    slk = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    lookup_pc = 32'h40;
    #1;
    checks++; if (lookup_taken !== 1'b0) begin errors++; $display("FAIL bht_init: got %b expected 0", lookup_taken); end
    for (int i = 0; i < 10; i++) begin
      send(sop[i], 32'h7, srt[i], 32'h40, 32'h80, 1'b0);
      note_delivery(stk[i]);
      checks++; if (lookup_taken !== slk[i]) begin errors++; $display("FAIL bht_step[%0d]: got %b expected %b", i, lookup_taken, slk[i]); end
    end
    // Entry 00: two taken updates, the second checked for same-cycle visibility.
    send(BR_BEQ, 32'h7, 32'h7, 32'h40, 32'h80, 1'b0);
    note_delivery(1'b1);
    checks++; if (lookup_taken !== 1'b0) begin errors++; $display("FAIL bht_to01: got %b expected 0", lookup_taken); end
    in_valid   = 1'b1;
    br_op      = BR_BEQ;
    rs_val     = 32'h7;
    rt_val     = 32'h7;
    br_pc      = 32'h40;
    br_target  = 32'h80;
    pred_taken = 1'b0;
    #1;
    checks++; if (lookup_taken !== 1'b0) begin errors++; $display("FAIL bht_same_cycle: got %b expected 0", lookup_taken); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    note_delivery(1'b1);
    checks++; if (lookup_taken !== 1'b1) begin errors++; $display("FAIL bht_after_update: got %b expected 1", lookup_taken); end
    // Reserved op at entry 10: no training, flagged illegal.
    send(BR_RSVD, 32'h7, 32'h7, 32'h40, 32'h80, 1'b1);
    note_delivery(1'b1);
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL rsvd_illegal: got %b expected 1", illegal_op); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL rsvd_taken: got %b expected 0", taken); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rsvd_mispredict: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL rsvd_redirect: got %h expected 00000044", redirect_pc); end
    checks++; if (lookup_taken !== 1'b1) begin errors++; $display("FAIL rsvd_no_train: got %b expected 1", lookup_taken); end
    idle();
    checks++; if (mispredict_count !== exp_cnt) begin errors++; $display("FAIL bht_count: got %0d expected %0d", mispredict_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b0;
    send(BR_BEQ, 32'h1, 32'h1, 32'h500, 32'h600, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    // Second request waits while the first is held.
    in_valid   = 1'b1;
    br_op      = BR_BNE;
    rs_val     = 32'h1;
    rt_val     = 32'h2;
    br_pc      = 32'h700;
    br_target  = 32'h800;
    pred_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (redirect_pc !== 32'h600) begin errors++; $display("FAIL bp_hold_redirect[%0d]: got %h expected 00000600", i, redirect_pc); end
      checks++; if (mispredict_count !== 3'd0) begin errors++; $display("FAIL bp_hold_count[%0d]: got %0d expected 0", i, mispredict_count); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b expected 1", out_valid); end
    checks++; if (redirect_pc !== 32'h800) begin errors++; $display("FAIL bp_second_redirect: got %h expected 00000800", redirect_pc); end
    checks++; if (mispredict_count !== 3'd1) begin errors++; $display("FAIL bp_first_count: got %0d expected 1", mispredict_count); end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    checks++; if (mispredict_count !== 3'd2) begin errors++; $display("FAIL bp_final_count: got %0d expected 2", mispredict_count); end
  endtask

  task automatic test_edges();
    apply_reset();
    send(BR_BEQ, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h10, 1'b0);
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL wrap_redirect: got %h expected 00000000", redirect_pc); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL wrap_taken: got %b expected 0", taken); end
    idle();
    out_ready = 1'b0;
    send(BR_JUMP, 32'h0, 32'h0, 32'h20, 32'h80, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL midrst_redirect: got %h expected 00000000", redirect_pc); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL midrst_mispredict: got %b expected 0", mispredict); end
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = '0;
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_replay: got %b expected 0", out_valid); end
    checks++; if (mispredict_count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", mispredict_count); end
  endtask

  task automatic test_count_saturate();
    apply_reset();
    for (int i = 0; i < 7; i++) send(BR_JUMP, 32'h0, 32'h0, 32'h0, 32'h8, 1'b0);
    idle();
    checks++; if (mispredict_count !== 3'd7) begin errors++; $display("FAIL sat_reach: got %0d expected 7", mispredict_count); end
    for (int i = 0; i < 2; i++) send(BR_JUMP, 32'h0, 32'h0, 32'h0, 32'h8, 1'b0);
    idle();
    checks++; if (mispredict_count !== 3'd7) begin errors++; $display("FAIL sat_hold: got %0d expected 7", mispredict_count); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_beq();
    test_conditions();
    test_bht_training();
    test_back_to_back();
    test_edges();
    test_count_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete by 200000");
    $fatal(1);
  end

endmodule
